serial_shift_scheduler: RTL and testbench

Frame controller for the serial shift datapath. Two requesters each offer a WIDTH-bit parallel word through a valid/ready handshake. The block grants the shared serial line round-robin, loads the granted word into its internal shift register, and shifts it out MSB-first, one bit per clock. It then enforces an inter-frame gap and pulses a done strobe. It sits between producer logic and the single serial output line.

---
 rtl/serial_shift_scheduler_if.sv | 26 ++
 rtl/serial_shift_scheduler.sv | 102 ++++++++++
 tb/tb_serial_shift_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_shift_scheduler_if.sv
// Requester handshakes and serial-line outputs of the shift scheduler.
// The master side is the producer/observer and the slave side is the scheduler.
interface serial_shift_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             serial_out;
    logic             frame_active;
    logic             grant_id;
    logic             frame_done;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, serial_out, frame_active, grant_id, frame_done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, serial_out, frame_active, grant_id, frame_done
    );
endinterface

// File: rtl/serial_shift_scheduler.sv
// Round-robin frame controller: it accepts a word from one of two requesters,
// shifts the word out MSB-first, and then holds the line idle for an inter-frame gap.
module serial_shift_scheduler #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic clk,
    input  logic clear,
    serial_shift_scheduler_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             done_q, done_d;

    logic pick1;
    logic idle_open;
    logic ready0;
    logic ready1;

    // Requester 1 wins when it is the only requester or when requester 0 owned the previous frame.
    assign pick1     = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    assign idle_open = (state_q == ST_IDLE) && !clear;
    assign ready0    = idle_open && bus.req0_valid && !pick1;
    assign ready1    = idle_open && pick1;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready0 || ready1) begin
                    shift_d      = ready1 ? bus.req1_data : bus.req0_data;
                    grant_d      = ready1;
                    last_grant_d = ready1;
                    bit_cnt_d    = '0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line is gated by the state, so it stays low outside SHIFT regardless of any shift-register residue.
    assign bus.serial_out   = (state_q == ST_SHIFT) && shift_q[WIDTH-1];
    assign bus.frame_active = (state_q == ST_SHIFT);
    assign bus.grant_id     = grant_q;
    assign bus.frame_done   = done_q;
    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
endmodule

// File: tb/tb_serial_shift_scheduler.sv
// Directed bench: a GAP=1 scheduler (u_*) and a GAP=0 scheduler (z_*) share the clock and the clear input.
module tb_serial_shift_scheduler;
    logic clk;
    logic clear;
    int   n_cmp;
    int   n_err;

    serial_shift_scheduler_if #(.WIDTH(4)) u_if ();
    serial_shift_scheduler_if #(.WIDTH(4)) z_if ();

    serial_shift_scheduler #(.WIDTH(4), .GAP(1)) u_dut (.clk(clk), .clear(clear), .bus(u_if));
    serial_shift_scheduler #(.WIDTH(4), .GAP(0)) z_dut (.clk(clk), .clear(clear), .bus(z_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic so(int d);
        return (d == 0) ? u_if.serial_out : z_if.serial_out;
    endfunction
    function automatic logic fa(int d);
        return (d == 0) ? u_if.frame_active : z_if.frame_active;
    endfunction
    function automatic logic gid(int d);
        return (d == 0) ? u_if.grant_id : z_if.grant_id;
    endfunction
    function automatic logic dn(int d);
        return (d == 0) ? u_if.frame_done : z_if.frame_done;
    endfunction
    function automatic logic r0(int d);
        return (d == 0) ? u_if.req0_ready : z_if.req0_ready;
    endfunction
    function automatic logic r1(int d);
        return (d == 0) ? u_if.req1_ready : z_if.req1_ready;
    endfunction

    // Runs one frame. Entry is the IDLE cycle that holds the accept. Exit is the next cycle whose ready outputs may accept.
    task automatic frame(input int d, input logic g, input logic [3:0] w, input bit drop,
                         input logic nr0, input logic nr1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0 && drop) begin
                if (d == 0) begin u_if.req0_valid = 1'b0; u_if.req1_valid = 1'b0; end
                else        begin z_if.req0_valid = 1'b0; z_if.req1_valid = 1'b0; end
            end
            chk($sformatf("d%0d bit%0d", d, i), 32'(so(d)), 32'(w[3-i]));
            chk($sformatf("d%0d active%0d", d, i), 32'(fa(d)), 32'd1);
            chk($sformatf("d%0d rdy_shift%0d", d, i), {30'd0, r1(d), r0(d)}, 32'd0);
            if (i == 0) chk($sformatf("d%0d grant", d), 32'(gid(d)), 32'(g));
        end
        tick();
        chk($sformatf("d%0d done", d), 32'(dn(d)), 32'd1);
        chk($sformatf("d%0d line_after", d), {30'd0, fa(d), so(d)}, 32'd0);
        if (d == 0) begin
            chk("d0 rdy_gap", {30'd0, r1(d), r0(d)}, 32'd0);
            tick();
            chk("d0 done_off", 32'(dn(d)), 32'd0);
            chk("d0 line_idle", {30'd0, fa(d), so(d)}, 32'd0);
        end
        chk($sformatf("d%0d next_rdy", d), {30'd0, r1(d), r0(d)}, {30'd0, nr1, nr0});
        $display("frame d%0d grant=%0d word=%b", d, g, w);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear = 1'b1;
        u_if.req0_valid = 1'b1; u_if.req0_data = 4'b1011;
        u_if.req1_valid = 1'b0; u_if.req1_data = 4'b0000;
        z_if.req0_valid = 1'b0; z_if.req0_data = 4'b0000;
        z_if.req1_valid = 1'b0; z_if.req1_data = 4'b0000;

        // While clear is high, every output is at its reset value and ready stays low even with a valid request.
        @(negedge clk);
        chk("rst outputs", {28'd0, u_if.frame_done, u_if.grant_id, u_if.frame_active, u_if.serial_out}, 32'd0);
        chk("rst ready", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd0);
        $display("reset checked");

        // Test 1: a single req0 word 1011 is sent with GAP=1.
        clear = 1'b0;
        #1;
        chk("t1 ready0", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd1);
        frame(0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0);

        // Test 2: both requesters stay valid after a fresh reset, and the grants alternate 0,1,0,1.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        u_if.req0_valid = 1'b1; u_if.req0_data = 4'b1100;
        u_if.req1_valid = 1'b1; u_if.req1_data = 4'b0011;
        #1;
        chk("t2 first_rdy", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd1);
        frame(0, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
        frame(0, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;

        // Test 3: req1 is the only requester and wins every frame.
        u_if.req1_valid = 1'b1; u_if.req1_data = 4'b0110;
        #1;
        chk("t3 rdy", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd2);
        frame(0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
        u_if.req1_valid = 1'b0;

        // Test 4: clear is asserted off-edge in the third bit, then the full frame is resent.
        u_if.req0_valid = 1'b1; u_if.req0_data = 4'b1011;
        #1;
        chk("t4 rdy", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd1);
        tick();
        chk("t4 b0", 32'(u_if.serial_out), 32'd1);
        chk("t4 grant", 32'(u_if.grant_id), 32'd0);
        tick();
        chk("t4 b1", 32'(u_if.serial_out), 32'd0);
        tick();
        chk("t4 b2", 32'(u_if.serial_out), 32'd1);
        #2 clear = 1'b1;
        #1;
        chk("t4 abort line", {29'd0, u_if.grant_id, u_if.frame_active, u_if.serial_out}, 32'd0);
        chk("t4 abort rdy", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd0);
        tick();
        chk("t4 no done", 32'(u_if.frame_done), 32'd0);
        tick();
        chk("t4 no done2", 32'(u_if.frame_done), 32'd0);
        clear = 1'b0;
        #1;
        chk("t4 rdy after clear", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd1);
        frame(0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0);
        $display("clear abort checked");

        // Test 5: changing the data during SHIFT does not affect the word being sent.
        u_if.req0_valid = 1'b1; u_if.req0_data = 4'b1011;
        #1;
        chk("t5 rdy", {30'd0, u_if.req1_ready, u_if.req0_ready}, 32'd1);
        tick();
        chk("t5 b0", 32'(u_if.serial_out), 32'd1);
        u_if.req0_data = 4'b0100;
        u_if.req0_valid = 1'b0;
        tick();
        chk("t5 b1", 32'(u_if.serial_out), 32'd0);
        tick();
        chk("t5 b2", 32'(u_if.serial_out), 32'd1);
        tick();
        chk("t5 b3", 32'(u_if.serial_out), 32'd1);
        tick();
        chk("t5 done", 32'(u_if.frame_done), 32'd1);
        tick();
        chk("t5 done_off", 32'(u_if.frame_done), 32'd0);
        $display("data change in shift checked");

        // Test 6: with GAP=0, one zero cycle separates frames, and the done cycle accepts the next word.
        z_if.req0_valid = 1'b1; z_if.req0_data = 4'b1100;
        z_if.req1_valid = 1'b1; z_if.req1_data = 4'b0011;
        #1;
        chk("t6 first_rdy", {30'd0, z_if.req1_ready, z_if.req0_ready}, 32'd1);
        frame(1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1);
        frame(1, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
        frame(1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1);
        z_if.req0_valid = 1'b0;
        z_if.req1_valid = 1'b0;
        tick();
        chk("t6 idle", {30'd0, z_if.frame_active, z_if.serial_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
